imul_iterative: RTL



---
 rtl/imul_pkg.sv | 25 ++
 rtl/imul_step.sv | 23 ++
 rtl/imul_iterative.sv | 112 +++++++++++
 3 files changed

// File: rtl/imul_pkg.sv
// Shared definitions for the iterative IMUL datapath: FSM encodings and
// elaboration-time sizing helpers.
package imul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } imul_state_e;

  // Ceiling log2, evaluated at elaboration to size counters and shifters.
  function automatic int imul_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/imul_step.sv
// One shift-and-add step of the iterative multiplier: adds the partial product
// of the multiplicand and a BITS_PER_CYCLE slice of the multiplier, shifted.
module imul_step #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHW            = 5
) (
  input  logic [2*WIDTH-1:0]        i_acc,
  input  logic [WIDTH-1:0]          i_mag_a,
  input  logic [BITS_PER_CYCLE-1:0] i_slice,
  input  logic [SHW-1:0]            i_shift,
  output logic [2*WIDTH-1:0]        o_acc_next
);

  logic [2*WIDTH-1:0] w_partial;

  // Partial product widened before the shift so no bits are lost.
  always_comb begin
    w_partial  = (2*WIDTH)'(i_mag_a) * (2*WIDTH)'(i_slice);
    o_acc_next = i_acc + (w_partial << i_shift);
  end

endmodule

// File: rtl/imul_iterative.sv
// Iterative signed/unsigned multiplier with start/busy/done handshake.
// Operates on magnitudes and applies the sign to the final product.
module imul_iterative
  import imul_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iStart,
  input  logic                 iSigned,
  input  logic [WIDTH-1:0]     iA,
  input  logic [WIDTH-1:0]     iB,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   oResult
);

  localparam int N   = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = (imul_clog2(N) < 1) ? 1 : imul_clog2(N);
  localparam int SHW = imul_clog2(2 * WIDTH);

  imul_state_e          r_state;
  logic [WIDTH-1:0]     r_mag_a;
  logic [WIDTH-1:0]     r_mag_b;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_step;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [SHW-1:0]       w_shift;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_final;
  logic                 w_last;

  // Magnitudes at capture; the most-negative value maps to itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    w_mag_a = (iSigned & iA[WIDTH-1]) ? -iA : iA;
    w_mag_b = (iSigned & iB[WIDTH-1]) ? -iB : iB;
    w_shift = SHW'(r_step) * SHW'(BITS_PER_CYCLE);
    w_last  = (r_step == CW'(N - 1));
    w_final = r_neg ? -w_acc_next : w_acc_next;
  end

  imul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHW            (SHW)
  ) u_step (
    .i_acc      (r_acc),
    .i_mag_a    (r_mag_a),
    .i_slice    (r_mag_b[BITS_PER_CYCLE-1:0]),
    .i_shift    (w_shift),
    .o_acc_next (w_acc_next)
  );

  // Control FSM, step counter and datapath registers in one place.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_step  <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oResult <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= ST_RUN;
            oBusy   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            oBusy   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_acc   <= w_acc_next;
          r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
          r_step  <= r_step + CW'(1);
          if (w_last) begin
            oResult <= w_final;
            r_state <= ST_DONE;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
          end else begin
            r_state <= ST_RUN;
            oBusy   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          oBusy   <= 1'b0;
          oDone   <= 1'b0;
        end
      endcase
    end
  end

endmodule
